// File: rtl/fc_argmax_head.sv
// rtl/fc_argmax_head.sv - streaming top-1/top-2 classification head with frame-length check
module fc_argmax_head #(
  parameter int NUM_CLASSES = 256,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [IDX_W-1:0]         out_class,
  output logic signed [DATA_W-1:0] out_score,
  output logic [DATA_W:0]          out_margin,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_t;

  localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                    state_q;
  logic [IDX_W-1:0]          cnt_q;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic signed [DATA_W-1:0]  second_q, second_d;
  logic                      long_q;
  logic [DATA_W:0]           margin_d;
  logic                      in_fire;
  logic                      at_last_idx;

  assign in_ready    = !rst && (state_q != HOLD);
  assign in_fire     = in_valid && in_ready;
  assign at_last_idx = (cnt_q == LAST_IDX);

  // Strict greater-than keeps the lower index on ties; the tied value drops into second.
  always_comb begin
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    if (cnt_q == '0) begin
      best_d     = in_data;
      second_d   = MIN_VAL;
      best_idx_d = '0;
    end else if (in_data > best_q) begin
      second_d   = best_q;
      best_d     = in_data;
      best_idx_d = cnt_q;
    end else if (in_data > second_q) begin
      second_d   = in_data;
    end
    margin_d = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
      long_q     <= 1'b0;
      out_class  <= '0;
      out_score  <= '0;
      out_margin <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_fire) begin
            best_q     <= best_d;
            second_q   <= second_d;
            best_idx_q <= best_idx_d;
            if (in_last || at_last_idx) begin
              cnt_q      <= '0;
              out_class  <= best_idx_d;
              out_score  <= best_d;
              out_margin <= margin_d;
              out_err    <= in_last ^ at_last_idx;
              out_valid  <= 1'b1;
              long_q     <= !in_last && at_last_idx;
              state_q    <= HOLD;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= long_q ? DRAIN : COLLECT;
          end
        end
        DRAIN: begin
          // Tail of an over-long frame: swallow beats up to and including in_last.
          if (in_fire && in_last) begin
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_head.sv
// tb/tb_fc_argmax_head.sv - directed and randomised checks of fc_argmax_head with NUM_CLASSES=4
module tb_fc_argmax_head;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [7:0]         out_class;
  logic signed [15:0] out_score;
  logic [16:0]        out_margin;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  fc_argmax_head #(.NUM_CLASSES(N), .DATA_W(16), .IDX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_class  (out_class),
    .out_score  (out_score),
    .out_margin (out_margin),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one beat from a negedge; returns just after the posedge that accepts it.
  task automatic send(input int d, input bit last);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 32'(t), 32'(0));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  task automatic expect_result(input string tag, input int cls, input int score,
                               input int margin, input bit err, input int delay);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    repeat (delay) begin
      check({tag, "_rdy_hold"}, {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_class"},  {24'b0, out_class},  32'(cls));
    check({tag, "_score"},  {16'b0, out_score},  {16'b0, 16'(score)});
    check({tag, "_margin"}, {15'b0, out_margin}, 32'(margin));
    check({tag, "_err"},    {31'b0, out_err},    {31'b0, err});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ack"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int v[N];
    int bi, sec, gaps;
    logic signed [15:0] r;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_class", {24'b0, out_class}, 32'd0);
    check("rst_score", {16'b0, out_score}, 32'd0);
    check("rst_margin", {15'b0, out_margin}, 32'd0);
    check("rst_err", {31'b0, out_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    // Basic frame with out_ready already high: result one cycle after last beat.
    out_ready = 1'b1;
    send_frame(5, -3, 9, 2);
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_class", {24'b0, out_class}, 32'd2);
    check("t1_score", {16'b0, out_score}, 32'd9);
    check("t1_margin", {15'b0, out_margin}, 32'd4);
    check("t1_err", {31'b0, out_err}, 32'd0);
    check("t1_in_ready_hold", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("t1_in_ready_back", {31'b0, in_ready}, 32'd1);
    check("t1_out_valid_drop", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Tie frame, then backpressure while the next frame is offered.
    send_frame(7, 7, 1, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd100; in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_class", {24'b0, out_class}, 32'd0);
      check("bp_score", {16'b0, out_score}, 32'd7);
    end
    expect_result("tie", 0, 7, 0, 1'b0, 0);
    send_frame(-8, -2, -5, -32768);
    expect_result("neg", 1, -2, 3, 1'b0, 0);

    // Short frames, including single-beat ones.
    send(3, 1'b0);
    send(-1, 1'b1);
    expect_result("short2", 0, 3, 4, 1'b1, 0);
    send(-5, 1'b1);
    expect_result("short1", 0, -5, 32763, 1'b1, 0);
    send(-32768, 1'b1);
    expect_result("short1_min", 0, -32768, 0, 1'b1, 0);
    send_frame(1, 2, 3, 4);
    expect_result("after_short", 3, 4, 1, 1'b0, 0);

    // Long frame: result from first N beats, tail drained silently.
    send(1, 1'b0); send(4, 1'b0); send(2, 1'b0); send(0, 1'b0);
    expect_result("long", 1, 4, 2, 1'b1, 2);
    send(99, 1'b0);
    send(99, 1'b1);
    idle(3);
    check("drain_no_out", {31'b0, out_valid}, 32'd0);
    send_frame(-1, 32767, 32767, -32768);
    expect_result("after_long", 1, 32767, 0, 1'b0, 0);

    // Reset mid-frame and mid-hold.
    send(50, 1'b0);
    send(60, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    idle(2);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    send_frame(10, 20, -30, 15);
    expect_result("after_rst", 1, 20, 5, 1'b0, 0);
    send_frame(1, 1, 1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hold_rst_out_valid", {31'b0, out_valid}, 32'd0);

    // Randomised frames with gaps; expected max and runner-up found by two independent scans.
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < N; i++) begin
        r = 16'($urandom);
        v[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) - 4 : int'(r);
      end
      bi = 0;
      for (int i = 1; i < N; i++) if (v[i] > v[bi]) bi = i;
      sec = -32768;
      for (int i = 0; i < N; i++) if (i != bi && v[i] > sec) sec = v[i];
      for (int i = 0; i < N; i++) begin
        gaps = $urandom_range(0, 3);
        if (gaps > 1) idle(gaps - 1);
        send(v[i], i == N - 1);
      end
      expect_result("rand", bi, v[bi], v[bi] - sec, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
